// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber NTT datapath blocks.
//   Q        : Kyber modulus.
//   COEF_W   : width of a reduced coefficient.
//   MODIN_W  : width of an operand presented to the mod-Q reducer.
//   arb_state_e : state of the shared-reducer arbiter.
package ntt_pkg;

    localparam int unsigned Q       = 3329;
    localparam int unsigned COEF_W  = 12;
    localparam int unsigned MODIN_W = 25;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StGap  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_i : request vector, one bit per requester.
//   ptr_i : highest-priority index for this pick.
//   idx_o : first requesting index at or after ptr_i, wrapping modulo NUM_REQ.
//   any_o : at least one request is set (idx_o is only meaningful when high).
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int unsigned cand;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/modq_share_arb.sv
// Round-robin arbiter sharing one start/done mod-3329 reducer among NUM_REQ requesters.
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   req_i         : level request per requester; a_i holds the flattened operands
//                   (requester k at a_i[k*OP_W +: OP_W]), captured on that requester's grant.
//   gnt_o         : one-cycle pulse, operand captured.
//   done_o        : one-cycle pulse, r_o valid for the owner.
//   r_o           : last result, held until the next completion (0 after a timeout).
//   err_o         : sticky watchdog flag.
//   div_start_o / div_a_o / div_done_i / div_r_i : reducer handshake.
module modq_share_arb
    import ntt_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OP_W    = MODIN_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*OP_W-1:0] a_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [COEF_W-1:0]       r_o,
    output logic                    err_o,
    output logic                    div_start_o,
    output logic [OP_W-1:0]         div_a_o,
    input  logic                    div_done_i,
    input  logic [COEF_W-1:0]       div_r_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic [IDX_W-1:0] next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .idx_o (win_idx),
        .any_o (any_req)
    );

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            r_o         <= '0;
            err_o       <= 1'b0;
            div_start_o <= 1'b0;
            div_a_o     <= '0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            unique case (state_q)
                StIdle, StGap: begin
                    if (any_req) begin
                        div_a_o          <= a_i[32'(win_idx) * OP_W +: OP_W];
                        div_start_o      <= 1'b1;
                        gnt_o[win_idx]   <= 1'b1;
                        owner_q          <= win_idx;
                        cnt_q            <= '0;
                        state_q          <= StBusy;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    // A real completion beats a watchdog expiry in the same cycle.
                    if (div_done_i || (cnt_q == CntMax)) begin
                        r_o              <= div_done_i ? div_r_i : '0;
                        err_o            <= err_o | ~div_done_i;
                        done_o[owner_q]  <= 1'b1;
                        div_start_o      <= 1'b0;
                        ptr_q            <= next_ptr;
                        state_q          <= StGap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
